// File: rtl/wb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_hilo_ctrl
// Description : MIPS writeback-stage controller. Registers the retiring
//               instruction and drives the GPR write port. Owns the HI/LO
//               registers and counts outstanding MULT/DIV operations.
//               MFHI/MFLO/MTHI/MTLO are interlocked against pending results.
// Ports       : clk, rst_n (async, active low)
//               in_*           MEM-stage instruction and operands; in_ready
//               flush          squashes the MEM-stage instruction
//               md_issue/md_valid/md_hi/md_lo   mul/div issue and result
//               rf_we/rf_waddr/rf_wdata          registered GPR write port
//               hi_q/lo_q      HI/LO contents
//               md_busy/md_full  decoded from the registered pending count
//               proto_err      sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hilo_ctrl #(
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int MD_MAX_OUT = 2,
  localparam int CNT_W     = $clog2(MD_MAX_OUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mem_to_reg,
  input  logic              in_regwrite,
  input  logic              in_hi_read,
  input  logic              in_lo_read,
  input  logic              in_hi_write,
  input  logic              in_lo_write,
  input  logic [RA_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_cp0_data,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic              flush,
  input  logic              md_issue,
  input  logic              md_valid,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic              md_busy,
  output logic              md_full,
  output logic              proto_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MD_MAX_OUT);

  logic [CNT_W-1:0]  pending_q, pending_d;
  logic              rf_we_q, rf_we_d;
  logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              proto_err_q, proto_err_d;

  logic              needs_hilo;
  logic              accept;
  logic              pend_nz;
  logic              md_ok;
  logic              issue_ok;
  logic [DATA_W-1:0] wb_data;

  assign needs_hilo = in_hi_read | in_lo_read | in_hi_write | in_lo_write;
  assign pend_nz    = (pending_q != '0);
  assign in_ready   = !(needs_hilo && pend_nz);
  assign accept     = in_valid & in_ready & ~flush;

  // A result is only taken when something is outstanding; a simultaneous
  // return frees a slot, so an issue at full is legal in that cycle.
  assign md_ok      = md_valid & pend_nz;
  assign issue_ok   = md_issue & ((pending_q != MAX_CNT) | md_ok);

  always_comb begin
    wb_data = in_mem_data;
    case (in_mem_to_reg)
      2'b00:   wb_data = in_mem_data;
      2'b01:   wb_data = in_hi_read ? hi_q : lo_q;
      2'b10:   wb_data = in_pc + DATA_W'(8);
      default: wb_data = in_cp0_data;
    endcase
  end

  always_comb begin
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pending_d   = pending_q;
    proto_err_d = proto_err_q;

    if (accept && in_regwrite && (in_rd != '0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = in_rd;
      rf_wdata_d = wb_data;
    end

    // The md result has priority over an MTHI/MTLO in the same cycle.
    if (md_ok) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (accept) begin
      if (in_hi_write) hi_d = in_rs_data;
      if (in_lo_write) lo_d = in_rs_data;
    end

    case ({issue_ok, md_ok})
      2'b10:   pending_d = pending_q + CNT_W'(1);
      2'b01:   pending_d = pending_q - CNT_W'(1);
      default: pending_d = pending_q;
    endcase

    if ((md_valid && !pend_nz) ||
        (md_issue && (pending_q == MAX_CNT) && !md_valid) ||
        (md_ok && accept && (in_hi_write || in_lo_write)))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pending_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pending_q   <= pending_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign md_busy   = pend_nz;
  assign md_full   = (pending_q == MAX_CNT);
  assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_hilo_ctrl
// Description : Self-checking bench for wb_hilo_ctrl: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_hilo_ctrl;

  localparam int DATA_W = 32;
  localparam int RA_W   = 5;
  localparam int MAXO   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_mem_to_reg;
  logic              in_regwrite;
  logic              in_hi_read, in_lo_read, in_hi_write, in_lo_write;
  logic [RA_W-1:0]   in_rd;
  logic [DATA_W-1:0] in_mem_data, in_pc, in_cp0_data, in_rs_data;
  logic              flush;
  logic              md_issue, md_valid;
  logic [DATA_W-1:0] md_hi, md_lo;
  logic              rf_we;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              md_busy, md_full, proto_err;

  wb_hilo_ctrl #(.DATA_W(DATA_W), .RA_W(RA_W), .MD_MAX_OUT(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_regwrite(in_regwrite),
    .in_hi_read(in_hi_read), .in_lo_read(in_lo_read),
    .in_hi_write(in_hi_write), .in_lo_write(in_lo_write),
    .in_rd(in_rd), .in_mem_data(in_mem_data), .in_pc(in_pc),
    .in_cp0_data(in_cp0_data), .in_rs_data(in_rs_data),
    .flush(flush), .md_issue(md_issue), .md_valid(md_valid),
    .md_hi(md_hi), .md_lo(md_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_q(hi_q), .lo_q(lo_q),
    .md_busy(md_busy), .md_full(md_full), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int        m_pend;
  bit        m_we;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata, m_hi, m_lo;
  bit        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_mem_to_reg = 2'b00; in_regwrite = 0;
    in_hi_read = 0; in_lo_read = 0; in_hi_write = 0; in_lo_write = 0;
    in_rd = '0; in_mem_data = '0; in_pc = '0; in_cp0_data = '0; in_rs_data = '0;
    flush = 0; md_issue = 0; md_valid = 0; md_hi = '0; md_lo = '0;
  endtask

  task automatic check_state();
    chk("rf_we",     {31'd0, rf_we},     {31'd0, m_we});
    chk("rf_waddr",  {27'd0, rf_waddr},  {27'd0, m_waddr});
    chk("rf_wdata",  rf_wdata,           m_wdata);
    chk("hi_q",      hi_q,               m_hi);
    chk("lo_q",      lo_q,               m_lo);
    chk("md_busy",   {31'd0, md_busy},   {31'd0, (m_pend != 0)});
    chk("md_full",   {31'd0, md_full},   {31'd0, (m_pend == MAXO)});
    chk("proto_err", {31'd0, proto_err}, {31'd0, m_err});
  endtask

  function automatic bit model_ready();
    bit uses_hilo;
    uses_hilo = in_hi_read | in_lo_read | in_hi_write | in_lo_write;
    return !(uses_hilo && m_pend > 0);
  endfunction

  // Applies the spec's retire / HI-LO / counter rules for one clock edge.
  task automatic model_step();
    bit        acc, res_taken;
    bit [31:0] val;
    acc = in_valid && model_ready() && !flush;
    case (in_mem_to_reg)
      2'd0: val = in_mem_data;
      2'd1: val = in_hi_read ? m_hi : m_lo;
      2'd2: val = in_pc + 32'd8;
      default: val = in_cp0_data;
    endcase
    res_taken = md_valid && m_pend > 0;
    if (md_valid && m_pend == 0) m_err = 1;
    if (md_issue && m_pend == MAXO && !md_valid) m_err = 1;
    if (res_taken && acc && (in_hi_write || in_lo_write)) m_err = 1;
    if (acc && in_regwrite && in_rd != 0) begin
      m_we = 1; m_waddr = in_rd; m_wdata = val;
    end else begin
      m_we = 0;
    end
    if (res_taken) begin
      m_hi = md_hi; m_lo = md_lo;
    end else if (acc) begin
      if (in_hi_write) m_hi = in_rs_data;
      if (in_lo_write) m_lo = in_rs_data;
    end
    if (res_taken) m_pend = m_pend - 1;
    if (md_issue && (m_pend < MAXO || res_taken) && !(res_taken && m_pend + 1 > MAXO))
      m_pend = m_pend + 1;
  endtask

  task automatic model_reset();
    m_pend = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_hi = 0; m_lo = 0; m_err = 0;
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic do_cycle();
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    model_step();
    @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    check_state();
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic retire(input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] pc);
    idle_inputs();
    in_valid = 1; in_regwrite = 1; in_mem_to_reg = sel; in_rd = rd;
    in_mem_data = data; in_pc = pc;
    do_cycle();
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    model_reset();
    @(negedge clk);
    check_state();
    @(negedge clk);
    rst_n = 1;

    // ADDU-style retire, then rd=0
    retire(2'b00, 5'd5, 32'h1234, 32'h0);
    chk("addu_we", {31'd0, rf_we}, 32'd1);
    chk("addu_wdata", rf_wdata, 32'h1234);
    retire(2'b00, 5'd0, 32'h9999, 32'h0);
    chk("rd0_we", {31'd0, rf_we}, 32'd0);

    // JAL link wrap
    retire(2'b10, 5'd31, 32'h0, 32'hFFFF_FFFC);
    chk("jal_wdata", rf_wdata, 32'h0000_0004);

    // MULT then MFHI interlock
    idle_inputs(); md_issue = 1; do_cycle();
    for (int c = 1; c <= 5; c++) begin
      idle_inputs();
      in_valid = 1; in_regwrite = 1; in_mem_to_reg = 2'b01; in_hi_read = 1; in_rd = 5'd8;
      if (c == 4) begin md_valid = 1; md_hi = 32'hAAAA_0000; md_lo = 32'h1; end
      #1;
      chk("mfhi_ready", {31'd0, in_ready}, {31'd0, (c == 5)});
      #(-0);
      do_cycle();
    end
    chk("mfhi_wdata", rf_wdata, 32'hAAAA_0000);

    // Counter bounds
    idle_inputs(); md_issue = 1; do_cycle();
    do_cycle();
    chk("full_after2", {31'd0, md_full}, 32'd1);
    md_valid = 1; md_hi = 32'h11; md_lo = 32'h22; do_cycle();
    chk("issue_valid_err", {31'd0, proto_err}, 32'd0);
    md_valid = 0; do_cycle();
    chk("third_issue_err", {31'd0, proto_err}, 32'd1);
    chk("third_issue_full", {31'd0, md_full}, 32'd1);

    // Stray md_valid
    do_reset();
    idle_inputs(); md_valid = 1; md_hi = 32'hDEAD; md_lo = 32'hBEEF; do_cycle();
    chk("stray_hi", hi_q, 32'h0);
    chk("stray_err", {31'd0, proto_err}, 32'd1);

    // Flushed MTLO
    do_reset();
    idle_inputs(); in_valid = 1; in_lo_write = 1; in_rs_data = 32'h55; flush = 1; do_cycle();
    chk("flush_lo", lo_q, 32'h0);
    idle_inputs(); in_valid = 1; in_lo_write = 1; in_rs_data = 32'h55; do_cycle();
    chk("mtlo_lo", lo_q, 32'h55);

    // Reset mid-stall
    idle_inputs(); md_issue = 1; do_cycle();
    idle_inputs(); in_valid = 1; in_hi_read = 1; in_mem_to_reg = 2'b01; in_regwrite = 1; in_rd = 5'd3;
    do_cycle();
    #2;
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 149) begin
        do_reset();
      end
      idle_inputs();
      in_valid      = ($urandom_range(0, 3) != 0);
      in_mem_to_reg = 2'($urandom_range(0, 3));
      in_regwrite   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0: in_hi_read = 1;
        1: in_lo_read = 1;
        2: in_hi_write = 1;
        3: in_lo_write = 1;
        4: begin in_hi_write = 1; in_lo_write = 1; end
        default: ;
      endcase
      in_rd       = 5'($urandom_range(0, 31));
      in_mem_data = $urandom;
      in_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      in_cp0_data = $urandom;
      in_rs_data  = $urandom;
      flush       = ($urandom_range(0, 7) == 0);
      md_issue    = ($urandom_range(0, 3) == 0);
      md_valid    = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      md_hi       = $urandom;
      md_lo       = $urandom;
      do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
